// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants, stereo sample type and counter width helper
//
// Purpose : common definitions for the I2S RX and TX blocks.
// Contents: SLOT_W_DEFAULT   default bits per channel slot
//           i2s_stereo_t     packed {l, r} stereo sample
//           cnt_width()      counter width for a modulus, never below 1 bit
package i2s_pkg;

  localparam int SLOT_W_DEFAULT = 32;

  typedef struct packed {
    logic [SLOT_W_DEFAULT-1:0] l;
    logic [SLOT_W_DEFAULT-1:0] r;
  } i2s_stereo_t;

  // $clog2(1) is 0, which would give zero-width counters for SCLK_DIV=1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_master_tx_if.sv
// rtl/i2s_master_tx_if.sv - stereo sample intake bus between mixer and I2S transmitter
//
// Purpose : valid/ready handshake carrying one stereo sample per transfer.
// Signals : s_valid   sample offered by the mixer
//           s_ready   transmitter holding register empty
//           s_data_l  left channel sample
//           s_data_r  right channel sample
// Modports: master = mixer side (drives valid/data), slave = transmitter side (drives ready)
interface i2s_master_tx_if
  import i2s_pkg::*;
#(
  parameter int SLOT_W = SLOT_W_DEFAULT
);

  logic              s_valid;
  logic              s_ready;
  logic [SLOT_W-1:0] s_data_l;
  logic [SLOT_W-1:0] s_data_r;

  modport master (
    output s_valid,
    output s_data_l,
    output s_data_r,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data_l,
    input  s_data_r,
    output s_ready
  );

endinterface

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - SCLK/LRCLK generator and bit position counter for the I2S master
//
// Purpose : divides clk down to SCLK, tracks the bit position within the stereo frame
//           and drives LRCLK from it.
// Ports   : clk          system clock
//           reset_n      asynchronous active-low reset
//           sclk         registered bit clock, starts low
//           lrclk        registered word select (0 left, 1 right), starts high
//           fall_evt     one-clk strobe in the cycle whose edge drops sclk
//           frame_start  fall_evt that wraps the bit counter to 0 (left slot begins)
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV = 4,
  parameter int SLOT_W   = SLOT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  output logic sclk,
  output logic lrclk,
  output logic fall_evt,
  output logic frame_start
);

  localparam int DIV_W = cnt_width(SCLK_DIV);
  localparam int BIT_W = cnt_width(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_nxt;
  logic             div_wrap;
  logic             rise_evt;

  assign div_wrap    = (div_cnt == DIV_LAST);
  assign rise_evt    = div_wrap && !sclk;
  assign fall_evt    = div_wrap && sclk;
  assign bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  // bit_cnt resets to the last position so the first fall after reset opens a left slot.
  assign frame_start = fall_evt && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      lrclk   <= 1'b1;
      bit_cnt <= BIT_LAST;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (rise_evt) begin
        sclk <= 1'b1;
      end else if (fall_evt) begin
        sclk <= 1'b0;
      end
      // LRCLK moves with the falling edge so it is settled a full half period
      // before the receiver samples on the next rising edge.
      if (fall_evt) begin
        bit_cnt <= bit_cnt_nxt;
        lrclk   <= (bit_cnt_nxt >= RIGHT_FIRST);
      end
    end
  end

endmodule

// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - I2S bus master transmitter with one-entry sample holding register
//
// Purpose : generates SCLK/LRCLK and serializes stereo samples MSB first onto SDATA.
//           A frame that starts with no sample held is sent as silence and flagged.
// Config  : I2S_TX_LEFT_JUSTIFIED_EN undefined -> standard I2S, SDATA one SCLK behind LRCLK
//           I2S_TX_LEFT_JUSTIFIED_EN defined   -> left-justified, MSB coincident with LRCLK edge
// Ports   : clk       system clock
//           reset_n   asynchronous active-low reset
//           s_if      sample intake bus (slave modport): s_valid, s_ready, s_data_l, s_data_r
//           sclk      bit clock
//           lrclk     word select, 0 = left slot, 1 = right slot
//           sdata     serial data, changes only on SCLK falling edges
//           underrun  one-clk pulse: frame started with the holding register empty
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV = 4,
  parameter int SLOT_W   = SLOT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  i2s_master_tx_if.slave s_if,
  output logic           sclk,
  output logic           lrclk,
  output logic           sdata,
  output logic           underrun
);

  localparam int FRAME_W = 2 * SLOT_W;

  logic               fall_evt;
  logic               frame_start;
  logic               hold_full;
  logic [FRAME_W-1:0] hold;
  logic [FRAME_W-1:0] load_word;
  logic [FRAME_W-1:0] shift;
  logic               accept;

  i2s_clkgen #(
    .SCLK_DIV (SCLK_DIV),
    .SLOT_W   (SLOT_W)
  ) u_clkgen (
    .clk         (clk),
    .reset_n     (reset_n),
    .sclk        (sclk),
    .lrclk       (lrclk),
    .fall_evt    (fall_evt),
    .frame_start (frame_start)
  );

  assign s_if.s_ready = !hold_full;
  assign accept       = s_if.s_valid && !hold_full;
  // An empty holding register at frame start sends silence rather than stale data.
  assign load_word    = hold_full ? hold : '0;
  // A sample accepted in the frame-load cycle itself is too late for this frame.
  assign underrun     = frame_start && !hold_full;

  // Holding register: accept and frame-load-with-full can never coincide,
  // because accept requires the register to be empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold      <= {s_if.s_data_l, s_if.s_data_r};
    end else if (frame_start) begin
      hold_full <= 1'b0;
    end
  end

  // Shift register: MSB is the bit for the current slot position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift <= '0;
    end else if (frame_start) begin
      shift <= load_word;
    end else if (fall_evt) begin
      shift <= {shift[FRAME_W-2:0], 1'b0};
    end
  end

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  // Shift MSB is itself a register updated on SCLK falls, so it drives SDATA directly.
  assign sdata = shift[FRAME_W-1];
`else
  // One-bit delay: SDATA carries the bit the shift register presented during the
  // previous SCLK period, so the right-channel LSB lands in bit 0 of the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdata <= 1'b0;
    end else if (fall_evt) begin
      sdata <= shift[FRAME_W-1];
    end
  end
`endif

endmodule
